cla_nibble_subtractor: RTL

- Multi-cycle unsigned/signed subtractor computing diff = a - b.
- Processes one 4-bit nibble per clock using a 4-bit carry-lookahead slice: a_nib + ~b_nib + carry_in.
- Keeps the inter-nibble carry in a register.
- It is the subtract-side counterpart of the team's registered 4-bit CLA adder, for datapaths wider than one slice.

---
 rtl/cla_nibble_subtractor_if.sv | 25 ++
 rtl/cla_nibble_subtractor.sv | 94 +++++++++
 2 files changed

// File: rtl/cla_nibble_subtractor_if.sv
// Operand/result bundle for the nibble-serial subtractor.
// The requester drives start/a/b; the subtractor returns status and result.
interface cla_nibble_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             ovf;
   logic             zero;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, ovf, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, ovf, zero
   );
endinterface

// File: rtl/cla_nibble_subtractor.sv
// Nibble-serial a - b through one 4-bit lookahead slice; latency NIB+1 edges from start.
// start is ignored while busy; results and flags hold until the next completion.
module cla_nibble_subtractor #(
   parameter int WIDTH = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   cla_nibble_subtractor_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_work, r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_done, r_borrow, r_ovf, r_zero;

   logic [3:0]       w_x, w_y, w_p, w_g, w_s;
   logic [4:0]       w_c;
   logic [WIDTH-1:0] w_res;

   // Subtraction as x + ~y + carry; every carry is a flat function of p/g and c0.
   always_comb begin
      w_x    = r_a[{r_cnt, 2'b00} +: 4];
      w_y    = ~r_b[{r_cnt, 2'b00} +: 4];
      w_p    = w_x ^ w_y;
      w_g    = w_x & w_y;
      w_c[0] = r_carry;
      w_c[1] = w_g[0] | (w_p[0] & r_carry);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & r_carry);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
      w_s    = w_p ^ w_c[3:0];
      w_res  = r_work;
      w_res[{r_cnt, 2'b00} +: 4] = w_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_work   <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_done   <= 1'b0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_carry <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_work  <= w_res;
               r_carry <= w_c[4];
               r_cnt   <= r_cnt + 1'b1;
               // Last slice: publish the full result, including the nibble just formed.
               if (r_cnt == LAST) begin
                  r_diff   <= w_res;
                  r_borrow <= ~w_c[4];
                  r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
                  r_zero   <= (w_res == '0);
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = (r_state == S_BUSY);
   assign bus.done   = r_done;
   assign bus.diff   = r_diff;
   assign bus.borrow = r_borrow;
   assign bus.ovf    = r_ovf;
   assign bus.zero   = r_zero;
endmodule
